// File: rtl/mdio_pkg.sv
// MDIO master shared types, frame field positions and header checks.
// Build option: define CLAUSE45_EN to also accept Clause 45 (ST=00) frames.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        FRAME,
        TA,
        RDATA
    } state_t;

    localparam logic [1:0] ST_C22       = 2'b01;
    localparam logic [1:0] ST_C45       = 2'b00;
    localparam logic [1:0] OP_C22_WR    = 2'b01;
    localparam logic [1:0] OP_C22_RD    = 2'b10;
    localparam logic [1:0] OP_C45_ADDR  = 2'b00;
    localparam logic [1:0] OP_C45_WR    = 2'b01;
    localparam logic [1:0] OP_C45_RDINC = 2'b10;
    localparam logic [1:0] OP_C45_RD    = 2'b11;

    localparam int ST_LO    = 30;
    localparam int OP_LO    = 28;
    localparam int PHYAD_LO = 23;
    localparam int REGAD_LO = 18;
    localparam int TA_LO    = 16;
    localparam int DATA_LO  = 0;

    localparam int HDR_BITS   = 14;
    localparam int TA_BITS    = 2;
    localparam int DATA_BITS  = 16;
    localparam int FRAME_BITS = 32;

    // Header check: which ST/OP combinations may start a frame.
    function automatic logic frame_valid(input logic [1:0] st,
                                         input logic [1:0] op);
        logic ok;
        ok = 1'b0;
        if (st == ST_C22)
            ok = (op == OP_C22_WR) || (op == OP_C22_RD);
`ifdef CLAUSE45_EN
        else if (st == ST_C45)
            ok = 1'b1;
`endif
        return ok;
    endfunction

    // Both clauses encode the read family with the OP msb set.
    function automatic logic frame_is_read(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdio_master_param_if.sv
// Host-side bundle of the MDIO master: request, frame, serial pins, status.
// The master modport is the controller's view, slave is the host/PHY view.
interface mdio_master_param_if;

    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        DONE;
    logic        BUSY;
    logic        ERR;

    modport master (
        input  MDIO_START, T_DATA, MDIO_IN,
        output MDC, MDIO_OUT, MDIO_OE, RD_DATA,
        output DATA_RDY, DONE, BUSY, ERR
    );

    modport slave (
        output MDIO_START, T_DATA, MDIO_IN,
        input  MDC, MDIO_OUT, MDIO_OE, RD_DATA,
        input  DATA_RDY, DONE, BUSY, ERR
    );

endinterface

// File: rtl/mdio_clk_gen.sv
// MDC generator: CLK_DIV cycles low then CLK_DIV cycles high while running.
// Strobes flag the CLK cycle whose closing edge makes MDC rise or fall.
module mdio_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick     = run && (cnt == LAST);
    assign mdc_rise = tick && !mdc;
    assign mdc_fall = tick && mdc;

    // Half-period counter; idles cleared with MDC low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master_param.sv
// MDIO management master with configurable MDC divider and preamble length.
// Build option: define CLAUSE45_EN to accept Clause 45 (ST=00) frames.
module mdio_master_param
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic CLK,
    input  logic RESET,
    mdio_master_param_if.master bus
);

    localparam logic [4:0] PRE_LAST   = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0] HDR_LAST   = 5'(HDR_BITS - 1);
    localparam logic [4:0] TA_LAST    = 5'(TA_BITS - 1);
    localparam logic [4:0] DATA_LAST  = 5'(DATA_BITS - 1);
    localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);
    localparam state_t     FIRST      = (PREAMBLE_LEN > 0) ? PREAMBLE
                                                           : FRAME;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  bit_cnt;
    logic [4:0]  cnt_nxt;
    logic [31:0] frame;
    logic [31:0] frame_src;
    logic        rd_q;
    logic        start_q;
    logic        start_edge;
    logic        hdr_valid;
    logic        accept;
    logic        reject;
    logic [15:0] sh_in;
    logic        out_nxt;
    logic        oe_nxt;
    logic        upd;
    logic        run;
    logic        mdc;
    logic        mdc_rise;
    logic        mdc_fall;

    logic        mdio_out;
    logic        mdio_oe;
    logic [15:0] rd_data;
    logic        data_rdy;
    logic        done;
    logic        busy;
    logic        err;

    assign run        = (state != IDLE);
    assign start_edge = bus.MDIO_START && !start_q;
    assign hdr_valid  = frame_valid(bus.T_DATA[ST_LO +: 2],
                                    bus.T_DATA[OP_LO +: 2]);
    assign accept     = (state == IDLE) && start_edge && hdr_valid;
    assign reject     = (state == IDLE) && start_edge && !hdr_valid;
    assign frame_src  = accept ? bus.T_DATA : frame;
    assign upd        = accept || mdc_fall;

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (CLK),
        .rst_n    (RESET),
        .run      (run),
        .mdc      (mdc),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall)
    );

    // State and per-phase bit counter registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    // Phase sequencing; every phase advances only on an MDC fall.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = FIRST;
            end
            PREAMBLE: begin
                if (mdc_fall && bit_cnt == PRE_LAST)
                    state_nxt = FRAME;
            end
            FRAME: begin
                if (mdc_fall) begin
                    if (rd_q && bit_cnt == HDR_LAST)
                        state_nxt = TA;
                    else if (!rd_q && bit_cnt == FRAME_LAST)
                        state_nxt = IDLE;
                end
            end
            TA: begin
                if (mdc_fall && bit_cnt == TA_LAST)
                    state_nxt = RDATA;
            end
            RDATA: begin
                if (mdc_fall && bit_cnt == DATA_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit about to be presented: counter and line value for the next bit.
    always_comb begin
        cnt_nxt = bit_cnt;
        out_nxt = 1'b0;
        oe_nxt  = 1'b0;
        if (state_nxt != state)
            cnt_nxt = '0;
        else if (mdc_fall)
            cnt_nxt = bit_cnt + 1'b1;
        unique case (state_nxt)
            PREAMBLE: begin
                out_nxt = 1'b1;
                oe_nxt  = 1'b1;
            end
            FRAME: begin
                out_nxt = frame_src[FRAME_LAST - cnt_nxt];
                oe_nxt  = 1'b1;
            end
            default: begin
                out_nxt = 1'b0;
                oe_nxt  = 1'b0;
            end
        endcase
    end

    // Frame latch, line drivers, read capture and status pulses.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            start_q  <= 1'b0;
            frame    <= '0;
            rd_q     <= 1'b0;
            sh_in    <= '0;
            mdio_out <= 1'b0;
            mdio_oe  <= 1'b0;
            rd_data  <= '0;
            data_rdy <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            start_q  <= bus.MDIO_START;
            err      <= reject;
            done     <= 1'b0;
            data_rdy <= 1'b0;
            if (upd) begin
                mdio_out <= out_nxt;
                mdio_oe  <= oe_nxt;
            end
            if (accept) begin
                frame <= bus.T_DATA;
                rd_q  <= frame_is_read(bus.T_DATA[OP_LO +: 2]);
                busy  <= 1'b1;
            end
            if (state == RDATA && mdc_rise)
                sh_in <= {sh_in[14:0], bus.MDIO_IN};
            if (run && state_nxt == IDLE) begin
                busy <= 1'b0;
                done <= 1'b1;
                if (rd_q) begin
                    rd_data  <= sh_in;
                    data_rdy <= 1'b1;
                end
            end
        end
    end

    assign bus.MDC      = mdc;
    assign bus.MDIO_OUT = mdio_out;
    assign bus.MDIO_OE  = mdio_oe;
    assign bus.RD_DATA  = rd_data;
    assign bus.DATA_RDY = data_rdy;
    assign bus.DONE     = done;
    assign bus.BUSY     = busy;
    assign bus.ERR      = err;

endmodule
